// File: rtl/serial_adder_nbit_pkg.sv
// serial_adder_nbit_pkg: FSM state encoding and parameter-legality check for the serial adder
`ifndef SERIAL_ADDER_NBIT_PKG_SV
`define SERIAL_ADDER_NBIT_PKG_SV
`define SA_PARAMS_OK(w, d) ((w) >= 1 && (d) >= 1 && ((w) % (d)) == 0)
package serial_adder_nbit_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage
`endif

// File: rtl/serial_adder_nbit_digit_adder.sv
// serial_adder_nbit_digit_adder: combinational DIGIT-bit ripple adder of full-adder cells
//   a, b   : DIGIT-bit addends
//   c_in   : carry into bit 0
//   sum    : DIGIT-bit sum
//   c_out  : carry out of the top bit
//   c_msb  : carry into the top bit (used for two's-complement overflow)
module serial_adder_nbit_digit_adder
    import serial_adder_nbit_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             c_in,
    output logic [DIGIT-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);
    logic [DIGIT:0] c;
    assign c[0] = c_in;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign c_out = c[DIGIT];
    assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/serial_adder_nbit.sv
// serial_adder_nbit: multi-cycle WIDTH-bit adder processing DIGIT bits per clock
//   clk, rst_n              : clock, asynchronous active-low reset
//   start_valid/start_ready : operand handshake (a, b, c_in captured when both high)
//   sum, c_out, ovf         : registered result, carry-out and overflow flag
//   done_valid/done_ready   : result handshake
module serial_adder_nbit
    import serial_adder_nbit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGIT  = 1,
    parameter bit SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             done_valid,
    input  logic             done_ready
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS + 1);

    if (!(`SA_PARAMS_OK(WIDTH, DIGIT))) begin : g_bad_params
        $error("serial_adder_nbit: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] ds;
    logic             dco, dcm, last;
    logic [WIDTH+DIGIT-1:0] s_cat;

    serial_adder_nbit_digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a     (a_sh[DIGIT-1:0]),
        .b     (b_sh[DIGIT-1:0]),
        .c_in  (carry),
        .sum   (ds),
        .c_out (dco),
        .c_msb (dcm)
    );

    // New digit enters at the MSB end; after STEPS shifts the register holds the full sum.
    assign s_cat       = {ds, s_sh};
    assign last        = cnt == CW'(STEPS - 1);
    assign start_ready = state == IDLE;
    assign done_valid  = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    carry <= c_in;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    s_sh  <= s_cat[WIDTH+DIGIT-1:DIGIT];
                    carry <= dco;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum   <= s_cat[WIDTH+DIGIT-1:DIGIT];
                        c_out <= dco;
                        ovf   <= SIGNED ? (dco ^ dcm) : dco;
                        state <= DONE;
                    end
                end
                DONE: if (done_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_nbit.sv
// tb_serial_adder_nbit: scoreboard bench over four adder configurations (D1/S0, D1/S1, D4, D8)
module tb_serial_adder_nbit;
    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
        logic [3:0] lat;
    } op_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_valid = 1'b0;
    logic       done_ready = 1'b1;
    logic       c_in = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    int         sel = 0;
    logic [7:0] sum_o [4];
    logic       co_o [4];
    logic       ov_o [4];
    logic       dv_o [4];
    logic       sr_o [4];
    op_t        q [$];
    op_t        e;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    logic       prev_dv = 1'b0;

    // Instance 0: D1 S0, 1: D1 S1, 2: D4 S0, 3: D8 S0.
    op_t vecs [11] = '{
        '{2'd0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 4'd8},
        '{2'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 4'd8},
        '{2'd0, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b1, 4'd8},
        '{2'd1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 4'd8},
        '{2'd1, 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 4'd8},
        '{2'd1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 4'd8},
        '{2'd2, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1, 4'd2},
        '{2'd2, 8'h37, 8'h29, 1'b0, 8'h60, 1'b0, 1'b0, 4'd2},
        '{2'd3, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b1, 4'd1},
        '{2'd3, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 4'd1},
        '{2'd0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b1, 4'd8}
    };

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        serial_adder_nbit #(
            .WIDTH  (8),
            .DIGIT  (i == 2 ? 4 : (i == 3 ? 8 : 1)),
            .SIGNED (i == 1)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .start_valid (start_valid && sel == i),
            .start_ready (sr_o[i]),
            .a           (a),
            .b           (b),
            .c_in        (c_in),
            .sum         (sum_o[i]),
            .c_out       (co_o[i]),
            .ovf         (ov_o[i]),
            .done_valid  (dv_o[i]),
            .done_ready  (done_ready && sel == i)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Edge counter and acceptance timestamp for latency checking.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && start_valid && sr_o[sel]) acc_cyc <= cyc + 1;
    end

    // Monitor: one scoreboard pop per new result presented.
    always @(negedge clk) begin
        if (dv_o[sel] && !prev_dv) begin
            if (q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("sum", 32'(sum_o[sel]), 32'(e.s));
                chk("c_out", 32'(co_o[sel]), 32'(e.co));
                chk("ovf", 32'(ov_o[sel]), 32'(e.ov));
                chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
            end
        end
        prev_dv <= dv_o[sel];
    end

    task automatic wait_done();
        int n;
        for (n = 0; n < 40 && !dv_o[sel]; n++) @(negedge clk);
        chk("done_timeout", 32'(dv_o[sel]), 32'd1);
    endtask

    task automatic run_op(input op_t o);
        @(negedge clk);
        sel = int'(o.idx);
        chk("start_ready_idle", 32'(sr_o[sel]), 32'd1);
        a = o.a;
        b = o.b;
        c_in = o.ci;
        start_valid = 1'b1;
        q.push_back(o);
        @(negedge clk);
        start_valid = 1'b0;
        a = ~o.a;
        b = o.b ^ 8'h5A;
        c_in = ~o.ci;
        wait_done();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_start_ready", 32'(sr_o[i]), 32'd1);
            chk("rst_done_valid", 32'(dv_o[i]), 32'd0);
            chk("rst_sum", 32'(sum_o[i]), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) run_op(vecs[i]);

        // Backpressure: result held while done_ready is low, pulsed start ignored.
        done_ready = 1'b0;
        run_op(vecs[10]);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(dv_o[0]), 32'd1);
            chk("bp_start_ready", 32'(sr_o[0]), 32'd0);
            chk("bp_sum", 32'(sum_o[0]), 32'h10);
            chk("bp_c_out", 32'(co_o[0]), 32'd1);
            start_valid = (k == 2);
            a = 8'hFF;
            b = 8'hFF;
            @(negedge clk);
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(dv_o[0]), 32'd0);
        chk("bp_release_ready", 32'(sr_o[0]), 32'd1);
        @(negedge clk);
        chk("bp_still_idle", 32'(sr_o[0]), 32'd1);

        // Asynchronous reset in the middle of RUN discards the operation.
        sel = 0;
        a = 8'h55;
        b = 8'h22;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrun_busy", 32'(sr_o[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_sum", 32'(sum_o[0]), 32'd0);
        chk("arst_c_out", 32'(co_o[0]), 32'd0);
        chk("arst_ovf", 32'(ov_o[0]), 32'd0);
        chk("arst_done_valid", 32'(dv_o[0]), 32'd0);
        chk("arst_start_ready", 32'(sr_o[0]), 32'd1);
        repeat (2) @(negedge clk);
        chk("arst_hold_ready", 32'(sr_o[0]), 32'd1);
        rst_n = 1'b1;
        run_op('{2'd0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 4'd8});

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
